execute: RTL and testbench
==========================

EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width in bits.
REQ-002 SHALL have parameter DIV_ITERS, default 64, iterative divider/multiplier step count; SHALL equal XLEN.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port moduleIn  input  REG_ID_EX  decoded instruction; fields used: valid, rs1, rs2, imm, aluOp, useImm, isMulDiv, mdOp[2:0] (RISC-V funct3), isWord, mem/wb/branch controls, wd, instrAddr, instr.
REQ-006 SHALL have port moduleOut  output  REG_EX_MEM  pipeline register toward memory stage.
REQ-007 SHALL have port forwardSource  output  FORWARD_SOURCE  bypass of current EX result.
REQ-008 SHALL have port ok_to_proceed  output  1  this stage can retire its instruction this cycle.
REQ-009 SHALL have port ok_to_proceed_overall  input  1  global advance enable, AND of all stage ok_to_proceed signals.

Function
REQ-010 SHALL compute non-M ALU ops combinationally; operand B = useImm ? imm : rs2.
REQ-011 SHALL run M-extension ops (isMulDiv=1) through FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-012 IDLE: on valid & isMulDiv, SHALL latch operands and mdOp, clear step counter, go BUSY.
REQ-013 BUSY: SHALL perform one shift-add (mul) or restoring-subtract (div/rem) step per cycle, increment counter, go DONE after DIV_ITERS steps.
REQ-014 DONE: SHALL hold result; on ok_to_proceed_overall SHALL go IDLE on the same edge moduleOut captures the result.
REQ-015 ok_to_proceed SHALL be ~valid | ~isMulDiv | (state==DONE).
REQ-016 Division latency: instruction valid at edge E0 -> DONE entered at E0+DIV_ITERS+1; ok_to_proceed high in the following cycle.
REQ-017 Signed ops SHALL operate on magnitudes and apply sign correction on entry to DONE; MULH/MULHSU/MULHU SHALL return upper XLEN bits of the 2*XLEN product.
REQ-018 Divide by zero SHALL give quotient all-ones, remainder = dividend, with no extra latency.
REQ-019 Signed overflow (most-negative / -1) SHALL give quotient = dividend, remainder 0.
REQ-020 isWord ops SHALL use operands' low 32 bits (sign- or zero-extended per op) and sign-extend the 32-bit result to XLEN.
REQ-021 On posedge with ok_to_proceed_overall SHALL load moduleOut from moduleIn, aluOut = ALU or M result; without it moduleOut SHALL hold.
REQ-022 forwardSource.valid SHALL be valid & wd!=0 & ~(isMulDiv & state!=DONE); wdData = current result.
REQ-023 FSM SHALL NOT restart on the instruction just retired: start only from IDLE.

Reset
REQ-024 rst low SHALL asynchronously set moduleOut.valid=0, state=IDLE, counter=0, result=0.
REQ-025 Reset mid-BUSY SHALL abandon the operation; the first instruction after release starts fresh.

Configuration
REQ-026 Macro FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU/MULW SHALL compute in one cycle (IDLE -> DONE at E0, stall exactly 1 cycle); divides stay iterative.
REQ-027 FAST_MUL_EN undefined: all M ops SHALL use the iterative path per REQ-013/016.

Verification
REQ-028 ADD rs1=5, rs2=7, overall=1 -> aluOut=12 next edge, ok_to_proceed never low.
REQ-029 DIV rs1=-20, rs2=3 -> ok_to_proceed low DIV_ITERS+1 cycles, then aluOut=-6; REM gives -2.
REQ-030 DIVU rs1=100, rs2=0 -> aluOut=0xFFFF_FFFF_FFFF_FFFF; REMU -> 100.
REQ-031 DIV rs1=0x8000_0000_0000_0000, rs2=-1 -> quotient 0x8000_0000_0000_0000; REM -> 0.
REQ-032 MULW rs1=0x7FFF_FFFF, rs2=2 -> 0xFFFF_FFFF_FFFF_FFFE; 1-cycle stall with FAST_MUL_EN, DIV_ITERS+1 without.
REQ-033 Assert rst low at BUSY step 30 -> moduleOut.valid=0, state IDLE immediately; next DIVU 9/3 -> 3.

Source files
------------

// File: rtl/execute.sv
// Execute stage: combinational integer ALU plus an iterative multiply/divide unit (IDLE/BUSY/DONE).
// Optional macro FAST_MUL_EN: multiplies finish in one cycle; divides always stay iterative.
module execute #(
    parameter int  XLEN      = 64,
    parameter int  DIV_ITERS = 64,
    localparam int ID_EX_W   = 4 * XLEN + 55,
    localparam int EX_MEM_W  = 3 * XLEN + 45,
    localparam int FWD_W     = XLEN + 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_EX_W-1:0]  moduleIn,
    output logic [EX_MEM_W-1:0] moduleOut,
    output logic [FWD_W-1:0]    forwardSource,
    output logic                ok_to_proceed,
    input  logic                ok_to_proceed_overall
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [3:0]      aluOp;
        logic            useImm;
        logic            isMulDiv;
        logic [2:0]      mdOp;
        logic            isWord;
        logic            memRead;
        logic            memWrite;
        logic [2:0]      memFunct3;
        logic            regWrite;
        logic            isBranch;
        logic [4:0]      wd;
        logic [XLEN-1:0] instrAddr;
        logic [31:0]     instr;
    } id_ex_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] aluOut;
        logic [XLEN-1:0] storeData;
        logic            memRead;
        logic            memWrite;
        logic [2:0]      memFunct3;
        logic            regWrite;
        logic            isBranch;
        logic [4:0]      wd;
        logic [XLEN-1:0] instrAddr;
        logic [31:0]     instr;
    } ex_mem_t;

    typedef struct packed {
        logic            valid;
        logic [4:0]      wd;
        logic [XLEN-1:0] wdData;
    } fwd_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10;
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(DIV_ITERS + 1);

    id_ex_t    in;
    ex_mem_t   out_q;
    fwd_t      fwd;
    md_state_e state_q, state_d;

    assign in            = moduleIn;
    assign moduleOut     = out_q;
    assign forwardSource = fwd;

    // ---------------- integer ALU ----------------
    logic [XLEN-1:0] op_b, alu_y;
    logic [31:0]     alu_w;

    assign op_b = in.useImm ? in.imm : in.rs2;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_y = '0;
        alu_w = '0;
        case (in.aluOp)
            ALU_ADD:    alu_y = in.rs1 + op_b;
            ALU_SUB:    alu_y = in.rs1 - op_b;
            ALU_SLL:    alu_y = in.rs1 << op_b[SHW-1:0];
            ALU_SLT:    alu_y = {{(XLEN-1){1'b0}}, $signed(in.rs1) < $signed(op_b)};
            ALU_SLTU:   alu_y = {{(XLEN-1){1'b0}}, in.rs1 < op_b};
            ALU_XOR:    alu_y = in.rs1 ^ op_b;
            ALU_SRL:    alu_y = in.rs1 >> op_b[SHW-1:0];
            ALU_SRA:    alu_y = $signed(in.rs1) >>> op_b[SHW-1:0];
            ALU_OR:     alu_y = in.rs1 | op_b;
            ALU_AND:    alu_y = in.rs1 & op_b;
            ALU_PASS_B: alu_y = op_b;
            default:    alu_y = '0;
        endcase
        case (in.aluOp)
            ALU_SUB: alu_w = in.rs1[31:0] - op_b[31:0];
            ALU_SLL: alu_w = in.rs1[31:0] << op_b[4:0];
            ALU_SRL: alu_w = in.rs1[31:0] >> op_b[4:0];
            ALU_SRA: alu_w = $signed(in.rs1[31:0]) >>> op_b[4:0];
            default: alu_w = in.rs1[31:0] + op_b[31:0];
        endcase
        if (in.isWord) alu_y = {{(XLEN-32){alu_w[31]}}, alu_w};
    end

    // ---------------- M-extension operand preparation ----------------
    logic            a_signed, b_signed, neg_a, neg_b, start, fast, last_step;
    logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, fast_result;

    // mdOp is funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
    assign a_signed = (in.mdOp != 3'd3) & ~(in.mdOp[2] & in.mdOp[0]);
    assign b_signed = in.mdOp[2] ? ~in.mdOp[0] : ~in.mdOp[1];
    assign ext_a = !in.isWord ? in.rs1 : {{(XLEN-32){a_signed & in.rs1[31]}}, in.rs1[31:0]};
    assign ext_b = !in.isWord ? in.rs2 : {{(XLEN-32){b_signed & in.rs2[31]}}, in.rs2[31:0]};
    assign neg_a = a_signed & ext_a[XLEN-1];
    assign neg_b = b_signed & ext_b[XLEN-1];
    assign mag_a = neg_a ? -ext_a : ext_a;
    assign mag_b = neg_b ? -ext_b : ext_b;
    assign start = in.valid & in.isMulDiv;

    // Sign-corrects the unsigned magnitude result and narrows word ops.
    function automatic logic [XLEN-1:0] md_finish(input logic [2:0] op, input logic word,
                                                  input logic na, input logic nb, input logic dz,
                                                  input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   r;
        prod = (na ^ nb) ? -{hi, lo} : {hi, lo};
        case (op)
            3'd0:              r = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:  r = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:        r = dz ? '1 : ((na ^ nb) ? -lo : lo);
            default:           r = na ? -hi : hi;
        endcase
        if (word) r = {{(XLEN-32){r[31]}}, r[31:0]};
        return r;
    endfunction

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod   = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
    assign fast        = ~in.mdOp[2];
    assign fast_result = md_finish(in.mdOp, in.isWord, neg_a, neg_b, 1'b0,
                                   fast_prod[2*XLEN-1:XLEN], fast_prod[XLEN-1:0]);
`else
    assign fast        = 1'b0;
    assign fast_result = '0;
`endif

    // ---------------- iterative shift-add / restoring-divide step ----------------
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] acc_q, lo_q, mag_b_q, result_q, acc_step, lo_step;
    logic [2:0]      op_q;
    logic            word_q, neg_a_q, neg_b_q, div_zero_q;
    logic [XLEN:0]   mul_sum, div_diff;

    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mag_b_q} : '0);
    assign div_diff  = {acc_q, lo_q[XLEN-1]} - {1'b0, mag_b_q};
    assign last_step = (cnt_q == CW'(DIV_ITERS - 1));

    always_comb begin
        acc_step = mul_sum[XLEN:1];
        lo_step  = {mul_sum[0], lo_q[XLEN-1:1]};
        if (op_q[2]) begin
            acc_step = div_diff[XLEN] ? {acc_q[XLEN-2:0], lo_q[XLEN-1]} : div_diff[XLEN-1:0];
            lo_step  = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = fast ? DONE : BUSY;
            BUSY:    if (last_step) state_d = DONE;
            DONE:    if (ok_to_proceed_overall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            result_q   <= '0;
            acc_q      <= '0;
            lo_q       <= '0;
            mag_b_q    <= '0;
            op_q       <= '0;
            word_q     <= 1'b0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start) begin
                    op_q       <= in.mdOp;
                    word_q     <= in.isWord;
                    neg_a_q    <= neg_a;
                    neg_b_q    <= neg_b;
                    div_zero_q <= (ext_b == '0);
                    acc_q      <= '0;
                    lo_q       <= mag_a;
                    mag_b_q    <= mag_b;
                    cnt_q      <= '0;
                    if (fast) result_q <= fast_result;
                end
                BUSY: begin
                    acc_q <= acc_step;
                    lo_q  <= lo_step;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step)
                        result_q <= md_finish(op_q, word_q, neg_a_q, neg_b_q, div_zero_q, acc_step, lo_step);
                end
                default: ;
            endcase
        end
    end

    // ---------------- retire, bypass and pipeline register ----------------
    logic [XLEN-1:0] ex_result;

    assign ex_result     = in.isMulDiv ? result_q : alu_y;
    assign ok_to_proceed = ~in.valid | ~in.isMulDiv | (state_q == DONE);
    assign fwd.valid     = in.valid & (in.wd != 5'd0) & ~(in.isMulDiv & (state_q != DONE));
    assign fwd.wd        = in.wd;
    assign fwd.wdData    = ex_result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
        end else if (ok_to_proceed_overall) begin
            out_q.valid     <= in.valid;
            out_q.aluOut    <= ex_result;
            out_q.storeData <= in.rs2;
            out_q.memRead   <= in.memRead;
            out_q.memWrite  <= in.memWrite;
            out_q.memFunct3 <= in.memFunct3;
            out_q.regWrite  <= in.regWrite;
            out_q.isBranch  <= in.isBranch;
            out_q.wd        <= in.wd;
            out_q.instrAddr <= in.instrAddr;
            out_q.instr     <= in.instr;
        end
    end
endmodule

// File: tb/tb_execute.sv
// Directed bench for execute: expected results queued at issue, compared when the instruction retires.
// Expected stall of multiplies follows FAST_MUL_EN.
module tb_execute;
    localparam int XLEN      = 64;
    localparam int DIV_ITERS = 64;
    localparam int BUDGET    = 200;
    localparam int DIV_STALL = DIV_ITERS + 1;
`ifdef FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = DIV_ITERS + 1;
`endif

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
                           ALU_XOR = 4'd5, ALU_SRA = 4'd7;
    localparam logic [2:0] MD_MUL = 3'd0, MD_MULH = 3'd1, MD_MULHSU = 3'd2, MD_MULHU = 3'd3,
                           MD_DIV = 3'd4, MD_DIVU = 3'd5, MD_REM = 3'd6, MD_REMU = 3'd7;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [3:0]      aluOp;
        logic            useImm;
        logic            isMulDiv;
        logic [2:0]      mdOp;
        logic            isWord;
        logic            memRead;
        logic            memWrite;
        logic [2:0]      memFunct3;
        logic            regWrite;
        logic            isBranch;
        logic [4:0]      wd;
        logic [XLEN-1:0] instrAddr;
        logic [31:0]     instr;
    } id_ex_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] aluOut;
        logic [XLEN-1:0] storeData;
        logic            memRead;
        logic            memWrite;
        logic [2:0]      memFunct3;
        logic            regWrite;
        logic            isBranch;
        logic [4:0]      wd;
        logic [XLEN-1:0] instrAddr;
        logic [31:0]     instr;
    } ex_mem_t;

    typedef struct packed {
        logic            valid;
        logic [4:0]      wd;
        logic [XLEN-1:0] wdData;
    } fwd_t;

    typedef struct {
        logic [63:0] data;
        string       tag;
    } exp_t;

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    logic    hold_n = 1'b1;
    logic    ok, overall;
    id_ex_t  din;
    ex_mem_t dout;
    fwd_t    fwd;
    exp_t    sb[$];
    int      checks = 0;
    int      errors = 0;

    assign overall = ok & hold_n;

    execute #(.XLEN(XLEN), .DIV_ITERS(DIV_ITERS)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .moduleIn              (din),
        .moduleOut             (dout),
        .forwardSource         (fwd),
        .ok_to_proceed         (ok),
        .ok_to_proceed_overall (overall)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic id_ex_t mk(input logic [3:0] alu_op, input logic md, input logic [2:0] md_op,
                                  input logic word, input logic use_imm, input logic [63:0] a,
                                  input logic [63:0] b, input logic [63:0] i, input logic [4:0] wd);
        id_ex_t r;
        r           = '0;
        r.valid     = 1'b1;
        r.rs1       = a;
        r.rs2       = b;
        r.imm       = i;
        r.aluOp     = alu_op;
        r.useImm    = use_imm;
        r.isMulDiv  = md;
        r.mdOp      = md_op;
        r.isWord    = word;
        r.regWrite  = (wd != 5'd0);
        r.wd        = wd;
        r.instrAddr = 64'h8000_1000;
        r.instr     = 32'h0000_0013;
        return r;
    endfunction

    // Presents one instruction, counts cycles with ok_to_proceed low, then checks the retired result.
    task automatic run_op(input id_ex_t ins, input logic [63:0] exp_val, input int exp_stall, input string tag);
        int   stall;
        exp_t e;
        @(negedge clk);
        din = ins;
        sb.push_back('{exp_val, tag});
        stall = 0;
        #1;
        while (!ok && stall < BUDGET) begin
            check({tag, " fwd.valid while stalled"}, 64'(fwd.valid), 64'd0);
            stall++;
            @(negedge clk);
            #1;
        end
        check({tag, " ok_to_proceed"}, 64'(ok), 64'd1);
        check({tag, " stall cycles"}, 64'(stall), 64'(exp_stall));
        check({tag, " fwd.valid"}, 64'(fwd.valid), 64'(ins.wd != 5'd0));
        check({tag, " fwd.wdData"}, fwd.wdData, exp_val);
        @(negedge clk);
        din = '0;
        e = sb.pop_front();
        check({e.tag, " out.valid"}, 64'(dout.valid), 64'd1);
        check({e.tag, " out.wd"}, 64'(dout.wd), 64'(ins.wd));
        check({e.tag, " out.aluOut"}, dout.aluOut, e.data);
    endtask

    initial begin
        exp_t e;
        din = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset out.valid", 64'(dout.valid), 64'd0);
        check("reset ok_to_proceed", 64'(ok), 64'd1);
        check("reset fwd.valid", 64'(fwd.valid), 64'd0);
        rst = 1'b1;

        run_op(mk(ALU_ADD, 0, 0, 0, 0, 64'd5, 64'd7, 0, 5'd1), 64'd12, 0, "add");
        run_op(mk(ALU_ADD, 0, 0, 0, 1, 64'd100, 64'd999, ONES, 5'd2), 64'd99, 0, "addi");
        run_op(mk(ALU_SUB, 0, 0, 0, 0, 64'd5, 64'd7, 0, 5'd3), 64'hFFFF_FFFF_FFFF_FFFE, 0, "sub");
        run_op(mk(ALU_SLT, 0, 0, 0, 0, ONES, 64'd1, 0, 5'd4), 64'd1, 0, "slt");
        run_op(mk(ALU_SLTU, 0, 0, 0, 0, ONES, 64'd1, 0, 5'd4), 64'd0, 0, "sltu");
        run_op(mk(ALU_SRA, 0, 0, 0, 0, MIN, 64'd4, 0, 5'd5), 64'hF800_0000_0000_0000, 0, "sra");
        run_op(mk(ALU_ADD, 0, 0, 1, 0, 64'h7FFF_FFFF, 64'd1, 0, 5'd6), 64'hFFFF_FFFF_8000_0000, 0, "addw");
        run_op(mk(ALU_XOR, 0, 0, 0, 0, 64'hF0, 64'hFF, 0, 5'd0), 64'h0F, 0, "xor wd0");

        run_op(mk(ALU_ADD, 1, MD_DIV, 0, 0, -64'sd20, 64'd3, 0, 5'd7), -64'sd6, DIV_STALL, "div");
        run_op(mk(ALU_ADD, 1, MD_REM, 0, 0, -64'sd20, 64'd3, 0, 5'd7), -64'sd2, DIV_STALL, "rem");
        run_op(mk(ALU_ADD, 1, MD_DIVU, 0, 0, 64'd100, 64'd0, 0, 5'd8), ONES, DIV_STALL, "divu by 0");
        run_op(mk(ALU_ADD, 1, MD_REMU, 0, 0, 64'd100, 64'd0, 0, 5'd8), 64'd100, DIV_STALL, "remu by 0");
        run_op(mk(ALU_ADD, 1, MD_DIV, 0, 0, MIN, ONES, 0, 5'd9), MIN, DIV_STALL, "div overflow");
        run_op(mk(ALU_ADD, 1, MD_REM, 0, 0, MIN, ONES, 0, 5'd9), 64'd0, DIV_STALL, "rem overflow");
        run_op(mk(ALU_ADD, 1, MD_DIVU, 1, 0, 64'h1_0000_0010, 64'd3, 0, 5'd10), 64'd5, DIV_STALL, "divuw");
        run_op(mk(ALU_ADD, 1, MD_REM, 1, 0, -64'sd7, 64'd2, 0, 5'd10), ONES, DIV_STALL, "remw");

        run_op(mk(ALU_ADD, 1, MD_MUL, 1, 0, 64'h7FFF_FFFF, 64'd2, 0, 5'd11), 64'hFFFF_FFFF_FFFF_FFFE, MUL_STALL, "mulw");
        run_op(mk(ALU_ADD, 1, MD_MUL, 0, 0, 64'd123456789, 64'd1000, 0, 5'd12), 64'd123456789000, MUL_STALL, "mul");
        run_op(mk(ALU_ADD, 1, MD_MULH, 0, 0, ONES, 64'd5, 0, 5'd12), ONES, MUL_STALL, "mulh");
        run_op(mk(ALU_ADD, 1, MD_MULHSU, 0, 0, ONES, ONES, 0, 5'd12), ONES, MUL_STALL, "mulhsu");
        run_op(mk(ALU_ADD, 1, MD_MULHU, 0, 0, ONES, ONES, 0, 5'd13), 64'hFFFF_FFFF_FFFF_FFFE, MUL_STALL, "mulhu");

        // moduleOut must hold while the global advance is withheld
        hold_n = 1'b0;
        @(negedge clk);
        din = mk(ALU_ADD, 0, 0, 0, 0, 64'd1, 64'd1, 0, 5'd14);
        repeat (3) @(negedge clk);
        #1;
        check("hold out.valid", 64'(dout.valid), 64'd1);
        check("hold out.aluOut", dout.aluOut, 64'hFFFF_FFFF_FFFF_FFFE);
        hold_n = 1'b1;
        run_op(mk(ALU_ADD, 0, 0, 0, 0, 64'd1, 64'd1, 0, 5'd14), 64'd2, 0, "add after hold");

        // DONE must persist until the advance arrives
        hold_n = 1'b0;
        @(negedge clk);
        din = mk(ALU_ADD, 1, MD_DIVU, 0, 0, 64'd100, 64'd7, 0, 5'd15);
        sb.push_back('{64'd14, "divu held"});
        repeat (DIV_STALL + 3) @(negedge clk);
        #1;
        check("held done ok_to_proceed", 64'(ok), 64'd1);
        check("held done fwd.wdData", fwd.wdData, 64'd14);
        check("held done out.aluOut", dout.aluOut, 64'd2);
        hold_n = 1'b1;
        @(negedge clk);
        din = '0;
        e = sb.pop_front();
        check({e.tag, " out.valid"}, 64'(dout.valid), 64'd1);
        check({e.tag, " out.aluOut"}, dout.aluOut, e.data);

        // reset in the middle of a division abandons it
        hold_n = 1'b0;
        @(negedge clk);
        din = mk(ALU_ADD, 1, MD_DIVU, 0, 0, 64'd1000, 64'd7, 0, 5'd16);
        repeat (31) @(negedge clk);
        #1;
        check("pre-reset out.valid", 64'(dout.valid), 64'd1);
        check("pre-reset ok_to_proceed", 64'(ok), 64'd0);
        #1;
        rst = 1'b0;
        #1;
        check("mid-busy reset out.valid", 64'(dout.valid), 64'd0);
        check("mid-busy reset state", 64'(dut.state_q), 64'd0);
        check("mid-busy reset counter", 64'(dut.cnt_q), 64'd0);
        din = '0;
        @(negedge clk);
        rst = 1'b1;
        hold_n = 1'b1;
        run_op(mk(ALU_ADD, 1, MD_DIVU, 0, 0, 64'd9, 64'd3, 0, 5'd17), 64'd3, DIV_STALL, "divu after reset");

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
